// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one countdown timer among N requesters, round-robin.
// Grants the timer, loads it with the owner's delay, waits for expiry and
// returns a one-cycle done. Dropping req mid-service cancels and resets the timer.
module timer_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_cycles,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic           timer_load,
    output logic [W-1:0]   timer_cycles,
    output logic           timer_reset,
    input  logic           timer_busy
);

    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StLoad, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [W-1:0]    len_q, len_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [N-1:0]    done_q, done_d;
    logic            load_q, load_d;
    logic [W-1:0]    cycles_q, cycles_d;
    logic            cancel;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [W-1:0]    win_cycles;
    logic [N-1:0]    win_oh;
    logic [N-1:0]    owner_oh;

    // Round-robin search: first set req bit upward from last+1, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= int'(N); i++) begin
            if (!win_found && req[(int'(last_q) + i) % int'(N)]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(last_q) + i) % int'(N));
            end
        end
        win_cycles = req_cycles[int'(win_idx) * int'(W) +: W];
        win_oh           = '0;
        win_oh[win_idx]  = 1'b1;
        owner_oh         = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // Next-state logic; grant/done/load are computed for the state being entered.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        len_d    = len_q;
        grant_d  = '0;
        done_d   = '0;
        load_d   = 1'b0;
        cycles_d = '0;
        cancel   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    owner_d = win_idx;
                    len_d   = win_cycles;
                    grant_d = win_oh;
                    state_d = StLoad;
                    // A zero-length delay skips the timer entirely.
                    if (win_cycles != '0) begin
                        load_d   = 1'b1;
                        cycles_d = win_cycles;
                    end
                end
            end
            StLoad: begin
                if (!req[owner_q]) begin
                    cancel  = 1'b1;
                    last_d  = owner_q;
                    state_d = StIdle;
                end else if (len_q != '0) begin
                    grant_d = owner_oh;
                    state_d = StWait;
                end else begin
                    grant_d = owner_oh;
                    done_d  = owner_oh;
                    state_d = StDone;
                end
            end
            StWait: begin
                if (!req[owner_q]) begin
                    cancel  = 1'b1;
                    last_d  = owner_q;
                    state_d = StIdle;
                end else if (!timer_busy) begin
                    grant_d = owner_oh;
                    done_d  = owner_oh;
                    state_d = StDone;
                end else begin
                    grant_d = owner_oh;
                end
            end
            StDone: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            last_q   <= IW'(N - 1);
            len_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            load_q   <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            len_q    <= len_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            load_q   <= load_d;
            cycles_q <= cycles_d;
        end
    end

    assign grant        = grant_q;
    assign done         = done_q;
    // A cancel in LOAD suppresses the already-registered load pulse.
    assign timer_load   = load_q & ~cancel;
    assign timer_cycles = timer_load ? cycles_q : '0;
    assign timer_reset  = ~reset_n | cancel;

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed scenarios followed by randomized traffic checked
// against a transaction-level round-robin model and a behavioural timer.
module tb_timer_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_cycles;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           timer_load;
    logic [W-1:0]   timer_cycles;
    logic           timer_reset;
    logic           timer_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    timer_arbiter #(.N(N), .W(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .req_cycles   (req_cycles),
        .grant        (grant),
        .done         (done),
        .timer_load   (timer_load),
        .timer_cycles (timer_cycles),
        .timer_reset  (timer_reset),
        .timer_busy   (timer_busy)
    );

    always #5 clk = ~clk;

    // Behavioural countdown timer: busy for exactly 'cycles' cycles after a load.
    logic [W-1:0] tcnt = '0;
    assign timer_busy = (tcnt != '0);
    always @(posedge clk) begin
        if (timer_reset)     tcnt <= '0;
        else if (timer_load) tcnt <= timer_cycles;
        else if (tcnt != '0) tcnt <= tcnt - 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_len(input int i, input logic [W-1:0] v);
        req_cycles[i*W +: W] = v;
    endtask

    task automatic wait_done(input string tag, input logic [N-1:0] exp, input int budget);
        for (int k = 0; k < budget && done == '0; k++) tick();
        chk(tag, done, exp);
    endtask

    // Reference rule: first requester after 'last', wrapping modulo N.
    function automatic int rr(input logic [N-1:0] m, input int last);
        for (int i = 1; i <= N; i++) begin
            if (m[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    int           rr_order[6];
    int           rr_exp[6];
    int           rr_n;
    logic [N-1:0] reraise;
    logic [N-1:0] pr;
    logic [N*W-1:0] ps;
    logic [N-1:0] dropped;
    logic [N-1:0] exp_grant, exp_done;
    logic         exp_load, cancel_now;
    int           m_last, m_owner, m_start, m_done_at, m_free_at;
    logic [W-1:0] m_len;
    logic         m_busy;

    initial begin
        reset_n    = 1'b0;
        req        = 4'b1111;
        req_cycles = '0;
        rr_exp     = '{0, 1, 3, 0, 1, 3};

        // Reset held three cycles with all requests high.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_grant", grant, 4'b0000);
            chk("rst_treset", timer_reset, 1'b1);
            chk("rst_load", timer_load, 1'b0);
            chk("rst_cycles", timer_cycles, 16'd0);
            chk("rst_done", done, 4'b0000);
        end
        req     = '0;
        reset_n = 1'b1;
        tick();
        chk("post_rst_treset", timer_reset, 1'b0);
        chk("post_rst_grant", grant, 4'b0000);

        // Single request: requester 2, length 5.
        set_len(2, 16'd5);
        req = 4'b0100;
        tick();
        chk("single_grant_c1", grant, 4'b0100);
        chk("single_load_c1", timer_load, 1'b1);
        chk("single_cycles_c1", timer_cycles, 16'd5);
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk("single_grant", grant, 4'b0100);
            chk("single_done", done, (c == 8) ? 4'b0100 : 4'b0000);
            chk("single_load", timer_load, 1'b0);
        end
        req = '0;
        tick();
        chk("single_idle_grant", grant, 4'b0000);

        // Zero length: requester 1.
        set_len(1, 16'd0);
        req = 4'b0010;
        tick();
        chk("zero_grant_c1", grant, 4'b0010);
        chk("zero_load_c1", timer_load, 1'b0);
        chk("zero_done_c1", done, 4'b0000);
        tick();
        chk("zero_done_c2", done, 4'b0010);
        chk("zero_load_c2", timer_load, 1'b0);
        req = '0;
        tick();
        chk("zero_idle_grant", grant, 4'b0000);

        // Round-robin from a fresh reset: requesters 0,1,3 with length 2.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) set_len(i, 16'd2);
        req     = 4'b1011;
        reraise = '0;
        rr_n    = 0;
        for (int k = 0; k < 200 && rr_n < 6; k++) begin
            tick();
            chk("rr_onehot", 32'($countones(grant) <= 1), 32'd1);
            if (done != '0) begin
                for (int i = 0; i < N; i++) if (done[i]) rr_order[rr_n] = i;
                rr_n++;
                req     = req & ~done;
                reraise = done;
                if (rr_n == 6) req = '0;
            end else if (reraise != '0) begin
                req     = req | reraise;
                reraise = '0;
            end
        end
        chk("rr_count", rr_n, 6);
        for (int i = 0; i < 6; i++) chk("rr_order", rr_order[i], rr_exp[i]);
        tick();

        // Cancel: requester 0 with length 100 dropped in cycle 10; 1 pending.
        set_len(0, 16'd100);
        set_len(1, 16'd3);
        req = 4'b0011;
        tick();
        chk("cancel_grant_c1", grant, 4'b0001);
        chk("cancel_cycles_c1", timer_cycles, 16'd100);
        for (int c = 2; c <= 10; c++) tick();
        chk("cancel_grant_c10", grant, 4'b0001);
        req[0] = 1'b0;
        #1;
        chk("cancel_treset_c10", timer_reset, 1'b1);
        chk("cancel_done_c10", done, 4'b0000);
        tick();
        chk("cancel_treset_c11", timer_reset, 1'b0);
        chk("cancel_done_c11", done, 4'b0000);
        chk("cancel_grant_c11", grant, 4'b0000);
        tick();
        chk("cancel_next_grant_c12", grant, 4'b0010);
        wait_done("cancel_next_done", 4'b0010, 20);
        req = '0;
        tick();

        // Reset during WAIT: no done, then re-arbitrate starting from requester 0.
        set_len(2, 16'd50);
        req = 4'b0100;
        for (int c = 1; c <= 5; c++) tick();
        chk("rstw_grant_wait", grant, 4'b0100);
        set_len(1, 16'd4);
        req     = 4'b1010;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rstw_grant", grant, 4'b0000);
            chk("rstw_done", done, 4'b0000);
            chk("rstw_treset", timer_reset, 1'b1);
        end
        reset_n = 1'b1;
        tick();
        chk("rstw_regrant", grant, 4'b0010);
        chk("rstw_reload", timer_load, 1'b1);
        chk("rstw_recycles", timer_cycles, 16'd4);
        wait_done("rstw_done_after", 4'b0010, 20);
        req = '0;

        // Randomized traffic against the transaction-level model.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        m_last    = N - 1;
        m_busy    = 1'b0;
        m_free_at = cyc;
        m_owner   = 0;
        m_start   = 0;
        m_done_at = 0;
        m_len     = '0;
        for (int t = 0; t < 800; t++) begin
            pr = req;
            ps = req_cycles;
            tick();
            if (!m_busy && (cyc - 1) >= m_free_at && pr != '0) begin
                m_owner   = rr(pr, m_last);
                m_len     = ps[m_owner*W +: W];
                m_busy    = 1'b1;
                m_start   = cyc;
                m_done_at = cyc + ((m_len == '0) ? 1 : int'(m_len) + 2);
                set_len(m_owner, W'($urandom));
            end
            exp_grant = m_busy ? (N'(1) << m_owner) : '0;
            exp_done  = (m_busy && cyc == m_done_at) ? (N'(1) << m_owner) : '0;
            exp_load  = m_busy && cyc == m_start && m_len != '0;
            chk("rand_grant", grant, exp_grant);
            chk("rand_done", done, exp_done);
            chk("rand_load", timer_load, exp_load);
            chk("rand_cycles", timer_cycles, exp_load ? m_len : '0);
            cancel_now = 1'b0;
            dropped    = '0;
            if (m_busy && cyc == m_done_at) begin
                m_busy           = 1'b0;
                m_last           = m_owner;
                m_free_at        = cyc + 1;
                req[m_owner]     = 1'b0;
                dropped[m_owner] = 1'b1;
            end else if (m_busy && $urandom_range(0, 15) == 0) begin
                m_busy           = 1'b0;
                m_last           = m_owner;
                m_free_at        = cyc + 1;
                req[m_owner]     = 1'b0;
                dropped[m_owner] = 1'b1;
                cancel_now       = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i] && !dropped[i] && $urandom_range(0, 3) == 0) begin
                    set_len(i, W'($urandom_range(0, 6)));
                    req[i] = 1'b1;
                end
            end
            #1;
            chk("rand_treset", timer_reset, cancel_now);
            if (cancel_now) chk("rand_cancel_load", timer_load, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
